// File: rtl/bench_step_pkg.sv
// Shared types and default sizing for the bench step controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bench_step_pkg;

   // Default parameter values for the controller and its trace register.
   localparam int IN_W_DEF      = 4;
   localparam int CNT_W_DEF     = 8;
   localparam int CAP_DEPTH_DEF = 8;

   // Controller FSM states.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_STEP   = 3'd2,
      S_SAMPLE = 3'd3,
      S_RESP   = 3'd4
   } state_t;

endpackage

// File: rtl/bench_trace_sr.sv
// Trace capture shift register: newest sample enters at bit 0, oldest falls off the top.
// Latency: one cycle from clr/shift_en to q.
// Backpressure: none; clr has priority over shift_en.
// Ports: clk, rst (sync, active-high), clr (zero the trace), shift_en (shift in din), din (sample), q (trace).
module bench_trace_sr #(
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             shift_en,
   input  logic             din,
   output logic [DEPTH-1:0] q
);

   logic [DEPTH-1:0] trace_q;
   logic [DEPTH-1:0] trace_d;

   always_comb begin
      trace_d = trace_q;
      if (clr) begin
         trace_d = '0;
      end else if (shift_en) begin
         trace_d = {trace_q[DEPTH-2:0], din};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         trace_q <= '0;
      end else begin
         trace_q <= trace_d;
      end
   end

   assign q = trace_q;

endmodule

// File: rtl/bench_step_ctrl.sv
// Single-command stepping controller: optionally resets a DUT, steps it N times, samples its output after each step.
// Latency: response 1 + 2N (+1 with init) cycles after the accepting edge.
// Backpressure: one command at a time; cmd_ready only in IDLE, response held until rsp_ready.
// Ports: blif_clk_net/blif_reset_net (clock, sync active-high reset); cmd_* (command in, valid/ready);
//        dut_in/dut_step/dut_rst/dut_out (DUT drive and observe); rsp_* (result out, valid/ready); busy.
module bench_step_ctrl
   import bench_step_pkg::*;
#(
   parameter int IN_W      = IN_W_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int CAP_DEPTH = CAP_DEPTH_DEF
) (
   input  logic                 blif_clk_net,
   input  logic                 blif_reset_net,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [IN_W-1:0]      cmd_vec,
   input  logic [CNT_W-1:0]     cmd_cycles,
   input  logic                 cmd_init,
   output logic [IN_W-1:0]      dut_in,
   output logic                 dut_step,
   output logic                 dut_rst,
   input  logic                 dut_out,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [CAP_DEPTH-1:0] rsp_trace,
   output logic [CNT_W-1:0]     rsp_steps,
   output logic                 busy
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state_q,  state_d;
   logic [IN_W-1:0]  dut_in_q, dut_in_d;
   logic [CNT_W-1:0] rem_q,    rem_d;
   logic [CNT_W-1:0] steps_q,  steps_d;
   logic             accept;

   always_comb begin
      state_d  = state_q;
      dut_in_d = dut_in_q;
      rem_d    = rem_q;
      steps_d  = steps_q;
      accept   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (cmd_valid) begin
               accept   = 1'b1;
               dut_in_d = cmd_vec;
               rem_d    = cmd_cycles;
               steps_d  = cmd_cycles;
               if (cmd_init) begin
                  state_d = S_INIT;
               end else if (cmd_cycles != '0) begin
                  state_d = S_STEP;
               end else begin
                  state_d = S_RESP;
               end
            end
         end
         S_INIT: begin
            state_d = (rem_q != '0) ? S_STEP : S_RESP;
         end
         S_STEP: begin
            state_d = S_SAMPLE;
         end
         S_SAMPLE: begin
            // Compare against one before decrementing so the full CNT_W range works without wrap.
            rem_d   = rem_q - CNT_ONE;
            state_d = (rem_q != CNT_ONE) ? S_STEP : S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge blif_clk_net) begin
      if (blif_reset_net) begin
         state_q  <= S_IDLE;
         dut_in_q <= '0;
         rem_q    <= '0;
         steps_q  <= '0;
      end else begin
         state_q  <= state_d;
         dut_in_q <= dut_in_d;
         rem_q    <= rem_d;
         steps_q  <= steps_d;
      end
   end

   // dut_out already reflects the step taken in the previous cycle, so SAMPLE captures it.
   bench_trace_sr #(
      .DEPTH (CAP_DEPTH)
   ) u_trace (
      .clk      (blif_clk_net),
      .rst      (blif_reset_net),
      .clr      (accept),
      .shift_en (state_q == S_SAMPLE),
      .din      (dut_out),
      .q        (rsp_trace)
   );

   assign cmd_ready = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign dut_rst   = (state_q == S_INIT);
   assign dut_step  = (state_q == S_STEP);
   assign rsp_valid = (state_q == S_RESP);
   assign dut_in    = dut_in_q;
   assign rsp_steps = steps_q;

endmodule

// File: doc/bench_step_ctrl.md
BENCH_STEP_CTRL -- requirements
Module: bench_step_ctrl

Interface
REQ-001 Parameters: IN_W, default 4, DUT primary-input width; CNT_W, default 8, step-count width; CAP_DEPTH, default 8, trace depth in samples.
REQ-002 blif_clk_net  input  1  single clock; all state updates on its rising edge.
REQ-003 blif_reset_net  input  1  synchronous, active-high reset.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  controller accepts command; high only in IDLE.
REQ-006 cmd_vec  input  IN_W  input vector applied to DUT for the whole run.
REQ-007 cmd_cycles  input  CNT_W  number of DUT steps N (0 allowed).
REQ-008 cmd_init  input  1  pulse DUT state reset before stepping.
REQ-009 dut_in  output  IN_W  registered copy of cmd_vec, held until the next accepted command.
REQ-010 dut_step  output  1  one-cycle clock-enable to DUT flops, one pulse per step.
REQ-011 dut_rst  output  1  one-cycle DUT state-reset pulse.
REQ-012 dut_out  input  1  DUT primary output (combinational from DUT state and dut_in).
REQ-013 rsp_valid  output  1  result available.
REQ-014 rsp_ready  input  1  result consumed.
REQ-015 rsp_trace  output  CAP_DEPTH  last CAP_DEPTH dut_out samples, newest at bit 0.
REQ-016 rsp_steps  output  CNT_W  N of completed run.
REQ-017 busy  output  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, INIT, STEP, SAMPLE, RESP; Moore outputs only.
REQ-019 IDLE: on cmd_valid&&cmd_ready latch cmd_vec into dut_in, latch N, clear rsp_trace, then go to INIT if cmd_init, else STEP if N>0, else RESP.
REQ-020 INIT: dut_rst=1 for exactly one cycle; next STEP if N>0, else RESP.
REQ-021 STEP: dut_step=1 for exactly one cycle; next SAMPLE.
REQ-022 SAMPLE: shift rsp_trace left one bit, insert dut_out at bit 0, decrement remaining count; next STEP if remaining>0 after decrement, else RESP.
REQ-023 Latency from accept edge (cycle T): rsp_valid first high at T+1+2N, plus 1 if cmd_init; N=0 without init gives T+1.
REQ-024 RESP: rsp_valid=1, rsp_trace and rsp_steps stable; leave to IDLE only on rsp_valid&&rsp_ready.
REQ-025 cmd_ready is low in RESP; a command offered during the rsp handshake cycle is accepted no earlier than the following cycle.
REQ-026 N>CAP_DEPTH: older samples shifted out; only the last CAP_DEPTH retained.
REQ-027 dut_step and dut_rst never high in the same cycle, never high outside STEP/INIT.
REQ-028 Remaining counter is CNT_W bits; N=2^CNT_W-1 completes without wrap.

Reset
REQ-029 blif_reset_net high at a clock edge forces IDLE regardless of state, including mid-run.
REQ-030 Reset values: cmd_ready=1 after release, dut_in=0, dut_step=0, dut_rst=0, rsp_valid=0, rsp_trace=0, rsp_steps=0, busy=0.
REQ-031 A run interrupted by reset produces no response and no further dut_step pulses.

Structure
REQ-032 Package bench_step_pkg holds the FSM state enum and default parameter constants.
REQ-033 One sub-module, bench_trace_sr: CAP_DEPTH-bit shift register with clear and shift-enable.

Verification (DUT model: dut_out toggles on each dut_step, 0 after dut_rst)
REQ-034 Reset held 2 cycles -> all outputs at REQ-030 values, cmd_ready=1 in first cycle after release.
REQ-035 cmd_vec=4'hA, N=3, init=1, accept at T -> dut_rst at T+1, 3 dut_step pulses, rsp_valid at T+8, rsp_trace=8'b00000101, rsp_steps=3, dut_in=4'hA.
REQ-036 N=0, init=0 -> rsp_valid at T+1, rsp_trace=0, rsp_steps=0, no dut_step or dut_rst pulse.
REQ-037 N=10, init=1 -> 10 dut_step pulses, rsp_trace=8'b10101010, rsp_steps=10.
REQ-038 rsp_ready low 5 cycles in RESP with cmd_valid high -> rsp fields stable, cmd_ready low, no command accepted; rsp_ready high -> IDLE next cycle.
REQ-039 Reset asserted during 2nd STEP of N=5 run -> next cycle IDLE, rsp_valid=0, no further dut_step pulses.
